// File: rtl/pwm_gen_multi_pkg.sv
// pwm_pkg: shared types and default sizes for the multi-channel PWM generator.
//   mode_e  : edge-aligned (sawtooth) or center-aligned (up/down) counting
//   dir_e   : counter direction, only meaningful in center mode
//   NCH_DEF : default number of channels
//   CW_DEF  : default counter/period/duty width
package pwm_pkg;

  typedef enum logic {PWM_EDGE, PWM_CENTER} mode_e;
  typedef enum logic {UP, DOWN} dir_e;

  localparam int NCH_DEF = 4;
  localparam int CW_DEF  = 8;

endpackage

// File: rtl/pwm_gen_multi_if.sv
// pwm_gen_multi_if: valid/ready configuration port of pwm_gen_multi.
//   cfg_valid  : master requests a new period/duty/mode set
//   cfg_ready  : slave can take a request (no config pending)
//   cfg_period : period terminal value P
//   cfg_duty   : per-channel duty, channel i at [i*CW +: CW]
//   cfg_center : 0 = edge-aligned, 1 = center-aligned
// Modports: master (drives the request), slave (the PWM block).
interface pwm_gen_multi_if
  import pwm_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int CW  = CW_DEF
);

  logic              cfg_valid;
  logic              cfg_ready;
  logic [CW-1:0]     cfg_period;
  logic [NCH*CW-1:0] cfg_duty;
  logic              cfg_center;

  modport master (
    output cfg_valid, cfg_period, cfg_duty, cfg_center,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_period, cfg_duty, cfg_center,
    output cfg_ready
  );

endinterface

// File: rtl/pwm_gen_multi_cmp_ch.sv
// pwm_cmp_ch: one PWM channel - duty compare against the shared counter and
// the registered output flop.
//   clk, rstn : clock, synchronous active-low reset
//   en        : run enable; output is idle while low
//   cnt       : shared period counter
//   duty      : this channel's active duty
//   pol       : output polarity (only when PWM_POL_EN is defined)
//   pwm       : registered PWM output
// Optional feature macro: PWM_POL_EN (adds pol; idle level becomes pol).
module pwm_cmp_ch
  import pwm_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          en,
  input  logic [CW-1:0] cnt,
  input  logic [CW-1:0] duty,
`ifdef PWM_POL_EN
  input  logic          pol,
`endif
  output logic          pwm
);

  logic active;

  // Unsigned compare: duty 0 never matches, duty above the counter's reach
  // always matches, which gives the constant-low/high corner cases for free.
  assign active = en && (cnt < duty);

  // Reset wins over polarity, so the output is 0 in reset regardless of pol.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pwm <= 1'b0;
    end else begin
`ifdef PWM_POL_EN
      pwm <= active ^ pol;
`else
      pwm <= active;
`endif
    end
  end

endmodule

// File: rtl/pwm_gen_multi.sv
// pwm_gen_multi: multi-channel runtime-programmable PWM generator.
// One shared period counter (edge or center aligned) feeds NCH compare
// channels. New period/duty/mode values are taken through a valid/ready port
// into shadow registers and only become active at a period boundary.
//   clk, rstn    : clock, synchronous active-low reset
//   en           : run enable (low = counter parked at 0, outputs idle)
//   cfg          : config port (pwm_gen_multi_if.slave)
//   pol          : per-channel polarity (only when PWM_POL_EN is defined)
//   pwm          : registered PWM outputs
//   period_start : one-cycle pulse aligned with the first pwm cycle of a period
//   cnt          : current counter value
// Optional feature macro: PWM_POL_EN.
module pwm_gen_multi
  import pwm_pkg::*;
#(
  parameter int NCH        = NCH_DEF,
  parameter int CW         = CW_DEF,
  parameter int PERIOD_RST = 99,
  parameter int DUTY_RST   = 25
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            en,
`ifdef PWM_POL_EN
  input  logic [NCH-1:0]  pol,
`endif
  pwm_gen_multi_if.slave  cfg,
  output logic [NCH-1:0]  pwm,
  output logic            period_start,
  output logic [CW-1:0]   cnt
);

  localparam logic [CW-1:0]     PERIOD_INIT = CW'(PERIOD_RST);
  localparam logic [NCH*CW-1:0] DUTY_INIT   = {NCH{CW'(DUTY_RST)}};

  dir_e              dir;
  mode_e             act_mode, shd_mode;
  logic [CW-1:0]     act_period, shd_period;
  logic [NCH*CW-1:0] act_duty, shd_duty;
  logic              pending;
  logic              boundary;

  assign cfg.cfg_ready = !pending;

  // Last cycle of the current period. In center mode with P==1 there is no
  // downward leg, so the single cnt==1 cycle is itself the boundary.
  always_comb begin
    boundary = 1'b0;
    if (!en || act_period == '0) begin
      boundary = 1'b1;
    end else if (act_mode == PWM_EDGE) begin
      boundary = (cnt == act_period);
    end else begin
      boundary = (cnt == CW'(1)) && (dir == DOWN || act_period == CW'(1));
    end
  end

  // Counter, direction, config handshake and shadow/active registers.
  // Accept requires pending==0 and apply requires pending==1, so a request
  // accepted in a boundary cycle waits for the following boundary.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt          <= '0;
      dir          <= UP;
      period_start <= 1'b0;
      pending      <= 1'b0;
      act_mode     <= PWM_EDGE;
      act_period   <= PERIOD_INIT;
      act_duty     <= DUTY_INIT;
      shd_mode     <= PWM_EDGE;
      shd_period   <= PERIOD_INIT;
      shd_duty     <= DUTY_INIT;
    end else begin
      if (cfg.cfg_valid && !pending) begin
        shd_period <= cfg.cfg_period;
        shd_duty   <= cfg.cfg_duty;
        shd_mode   <= cfg.cfg_center ? PWM_CENTER : PWM_EDGE;
        pending    <= 1'b1;
      end
      if (boundary && pending) begin
        act_period <= shd_period;
        act_duty   <= shd_duty;
        act_mode   <= shd_mode;
        pending    <= 1'b0;
      end

      if (boundary) begin
        cnt <= '0;
        dir <= UP;
      end else if (act_mode == PWM_EDGE) begin
        cnt <= cnt + 1'b1;
      end else if (dir == UP) begin
        if (cnt == act_period) begin
          dir <= DOWN;
          cnt <= cnt - 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= cnt - 1'b1;
      end

      period_start <= en && (cnt == '0);
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    pwm_cmp_ch #(.CW(CW)) u_ch (
      .clk  (clk),
      .rstn (rstn),
      .en   (en),
      .cnt  (cnt),
      .duty (act_duty[i*CW +: CW]),
`ifdef PWM_POL_EN
      .pol  (pol[i]),
`endif
      .pwm  (pwm[i])
    );
  end

endmodule

// File: tb/tb_pwm_gen_multi.sv
// tb_pwm_gen_multi: scoreboard bench for pwm_gen_multi.
// A reference model tracks each period as a phase index 0..L-1 (L = P+1 for
// edge, 2P for center, 1 for P==0) and derives cnt from the phase; it pushes
// the expected registered outputs for every clock into a queue, and a monitor
// pops and compares on the falling edge.
module tb_pwm_gen_multi;
  import pwm_pkg::*;

  localparam int NCH = 4;
  localparam int CW  = 8;

  typedef struct {
    logic [CW-1:0]  cnt;
    logic [NCH-1:0] pwm;
    logic           ps;
    logic           ready;
  } exp_t;

  logic           clk = 1'b0;
  logic           rstn;
  logic           en;
  logic [NCH-1:0] pol_v = '0;
  logic [NCH-1:0] pwm;
  logic           period_start;
  logic [CW-1:0]  cnt;

  pwm_gen_multi_if #(.NCH(NCH), .CW(CW)) cfg_bus ();

  pwm_gen_multi #(.NCH(NCH), .CW(CW), .PERIOD_RST(99), .DUTY_RST(25)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .en           (en),
`ifdef PWM_POL_EN
    .pol          (pol_v),
`endif
    .cfg          (cfg_bus),
    .pwm          (pwm),
    .period_start (period_start),
    .cnt          (cnt)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_mis = 0;
  exp_t exp_q[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_mis++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int period_len(int p, bit c);
    if (p == 0) return 1;
    return c ? 2 * p : p + 1;
  endfunction

  function automatic int cnt_of(int ph, int p, bit c);
    if (c && ph > p) return 2 * p - ph;
    return ph;
  endfunction

  int             m_p, s_p, m_phase, m_cur;
  bit             m_c, s_c, m_pend, m_live = 0, m_bnd, m_acc;
  int             m_duty[NCH];
  int             s_duty[NCH];
  logic [NCH-1:0] m_pwm;
  logic           m_ps;
  exp_t           m_e;

  always @(posedge clk) begin
    if (!rstn) begin
      m_p = 99; m_c = 0; s_p = 99; s_c = 0;
      for (int i = 0; i < NCH; i++) begin
        m_duty[i] = 25;
        s_duty[i] = 25;
      end
      m_pend = 0; m_phase = 0; m_pwm = '0; m_ps = 0; m_live = 1;
    end else if (m_live) begin
      m_cur = cnt_of(m_phase, m_p, m_c);
      m_bnd = !en || (m_phase == period_len(m_p, m_c) - 1);
      for (int i = 0; i < NCH; i++)
        m_pwm[i] = (en && (m_cur < m_duty[i])) ^ pol_v[i];
      m_ps  = en && (m_cur == 0);
      m_acc = cfg_bus.cfg_valid && !m_pend;
      if (m_bnd && m_pend) begin
        m_p = s_p; m_c = s_c; m_duty = s_duty; m_pend = 0;
      end
      if (m_acc) begin
        s_p = int'(cfg_bus.cfg_period);
        s_c = cfg_bus.cfg_center;
        for (int i = 0; i < NCH; i++) s_duty[i] = int'(cfg_bus.cfg_duty[i*CW +: CW]);
        m_pend = 1;
      end
      m_phase = (!en || m_bnd) ? 0 : m_phase + 1;
    end
    if (m_live) begin
      m_e.cnt   = CW'(cnt_of(m_phase, m_p, m_c));
      m_e.pwm   = m_pwm;
      m_e.ps    = m_ps;
      m_e.ready = !m_pend;
      exp_q.push_back(m_e);
    end
  end

  // ---------------- monitor ----------------
  exp_t got;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      got = exp_q.pop_front();
      checkOutput("cnt", 32'(cnt), 32'(got.cnt));
      checkOutput("pwm", 32'(pwm), 32'(got.pwm));
      checkOutput("period_start", 32'(period_start), 32'(got.ps));
      checkOutput("cfg_ready", 32'(cfg_bus.cfg_ready), 32'(got.ready));
    end
  end

  // ---------------- stimulus ----------------
  task automatic runCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [CW-1:0] p, input logic [NCH*CW-1:0] d, input logic c);
    int waited = 0;
    cfg_bus.cfg_period = p;
    cfg_bus.cfg_duty   = d;
    cfg_bus.cfg_center = c;
    cfg_bus.cfg_valid  = 1'b1;
    @(negedge clk);
    while (!cfg_bus.cfg_ready && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("cfg_accept", 32'(cfg_bus.cfg_ready), 32'd1);
    @(posedge clk);
    #1;
    cfg_bus.cfg_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not end, got timeout, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  logic [CW-1:0]     rp;
  logic [NCH*CW-1:0] rd;
  int                r;

  initial begin
    rstn = 1'b0;
    en   = 1'b0;
    cfg_bus.cfg_valid  = 1'b0;
    cfg_bus.cfg_period = '0;
    cfg_bus.cfg_duty   = '0;
    cfg_bus.cfg_center = 1'b0;
`ifdef PWM_POL_EN
    pol_v = NCH'(4'b0101);
`endif
    runCycles(3);
    rstn = 1'b1;
    en   = 1'b1;

    $display("[TB] default 100-cycle period, duty 25");
    runCycles(210);

    $display("[TB] P=9 duty {255,10,5,0} loaded mid-period");
    runCycles(17);
    applyStimulus(8'd9, {8'd255, 8'd10, 8'd5, 8'd0}, 1'b0);
    runCycles(110);

    $display("[TB] center mode P=4 duty0=2");
    applyStimulus(8'd4, {8'd4, 8'd5, 8'd0, 8'd2}, 1'b1);
    runCycles(40);

    $display("[TB] back-to-back config requests");
    applyStimulus(8'd6, {8'd1, 8'd3, 8'd6, 8'd7}, 1'b0);
    applyStimulus(8'd3, {8'd0, 8'd1, 8'd3, 8'd4}, 1'b1);
    runCycles(30);

    $display("[TB] en dropped with a pending config");
    applyStimulus(8'd12, {8'd2, 8'd6, 8'd12, 8'd13}, 1'b0);
    runCycles(2);
    en = 1'b0;
    runCycles(4);
    en = 1'b1;
    runCycles(30);

    $display("[TB] reset mid-period with a pending config");
    applyStimulus(8'd5, {8'd1, 8'd2, 8'd3, 8'd4}, 1'b1);
    runCycles(3);
    rstn = 1'b0;
    runCycles(2);
    rstn = 1'b1;
    runCycles(120);

    $display("[TB] P=0 and center P=1 corners");
    applyStimulus(8'd0, {8'd0, 8'd1, 8'd0, 8'd1}, 1'b0);
    runCycles(6);
    applyStimulus(8'd1, {8'd0, 8'd1, 8'd2, 8'd1}, 1'b1);
    runCycles(8);
    applyStimulus(8'd0, {8'd0, 8'd1, 8'd0, 8'd1}, 1'b1);
    runCycles(6);

    $display("[TB] randomized configs");
    for (int it = 0; it < 30; it++) begin
      r  = $urandom_range(0, 9);
      rp = (r == 0) ? CW'($urandom_range(0, 1)) : CW'($urandom_range(2, 20));
      for (int ch = 0; ch < NCH; ch++) begin
        r = $urandom_range(0, 9);
        rd[ch*CW +: CW] = (r == 0) ? 8'd0 : (r == 1) ? 8'd255 : CW'($urandom_range(0, int'(rp) + 2));
      end
      applyStimulus(rp, rd, 1'($urandom_range(0, 1)));
      runCycles($urandom_range(0, 50));
      if ($urandom_range(0, 4) == 0) begin
        en = 1'b0;
        runCycles($urandom_range(1, 3));
        en = 1'b1;
      end
    end
    runCycles(40);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
